// File: rtl/uart_bus_master_pkg.sv
// rtl/uart_bus_master_pkg.sv - command/response byte codes and parser states for the UART bus master.
package uart_bus_master_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'h57;
  localparam logic [7:0] CMD_READ    = 8'h52;
  localparam logic [7:0] RSP_OK      = 8'h4B;
  localparam logic [7:0] RSP_ERR     = 8'h45;
  localparam logic [7:0] RSP_UNKNOWN = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

endpackage

// File: rtl/uart_byte_phy.sv
// rtl/uart_byte_phy.sv - 8N1 byte receiver and transmitter, one bit period = UARTSPED+1 cycles.
module uart_byte_phy #(
  parameter logic [15:0] UARTSPED = 16'd269
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy
);
  localparam logic [15:0] HALF = UARTSPED >> 1;

  logic [1:0]  rx_sync;
  logic        rx_prev, rx_act;
  logic [3:0]  rx_idx;
  logic [15:0] rx_cnt;
  logic [7:0]  rx_sh;
  logic        rx_s;

  logic [8:0]  tx_sh;
  logic [3:0]  tx_idx;
  logic [15:0] tx_cnt;
  logic        tx_act, tx_last;

  assign rx_s    = rx_sync[1];
  assign rx_data = rx_sh;

  // Receiver goes idle at the stop-bit sample so a directly following start bit is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_act   <= 1'b0;
      rx_idx   <= '0;
      rx_cnt   <= '0;
      rx_sh    <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], rx};
      rx_prev  <= rx_s;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (!rx_act) begin
        if (rx_prev && !rx_s) begin
          rx_act <= 1'b1;
          rx_cnt <= '0;
          rx_idx <= '0;
        end
      end else begin
        rx_cnt <= (rx_cnt == UARTSPED) ? 16'd0 : rx_cnt + 16'd1;
        if (rx_cnt == UARTSPED) rx_idx <= rx_idx + 4'd1;
        if (rx_cnt == HALF) begin
          if (rx_idx == 4'd0) begin
            if (rx_s) rx_act <= 1'b0;
          end else if (rx_idx <= 4'd8) begin
            rx_sh <= {rx_s, rx_sh[7:1]};
          end else begin
            rx_act   <= 1'b0;
            rx_valid <= rx_s;
            rx_ferr  <= !rx_s;
          end
        end
      end
    end
  end

  // Ready again in the last stop-bit cycle so back-to-back bytes have no idle gap.
  assign tx_last = tx_act && (tx_idx == 4'd9) && (tx_cnt == UARTSPED);
  assign tx_busy = tx_act && !tx_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx     <= 1'b1;
      tx_act <= 1'b0;
      tx_sh  <= '1;
      tx_idx <= '0;
      tx_cnt <= '0;
    end else if (tx_start && !tx_busy) begin
      tx     <= 1'b0;
      tx_act <= 1'b1;
      tx_sh  <= {1'b1, tx_data};
      tx_idx <= '0;
      tx_cnt <= '0;
    end else if (tx_act) begin
      if (tx_cnt == UARTSPED) begin
        tx_cnt <= '0;
        tx_idx <= tx_idx + 4'd1;
        tx     <= tx_sh[0];
        tx_sh  <= {1'b1, tx_sh[8:1]};
        if (tx_idx == 4'd9) tx_act <= 1'b0;
      end else begin
        tx_cnt <= tx_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - UART command parser issuing single 32-bit bus reads/writes with serial responses.
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter logic [15:0] UARTSPED = 16'd269,
  parameter logic [15:0] TIMEOUT  = 16'd1023
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        uartRx_i,
  output logic        uartTx_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i
);
  state_t      state_q, state_d;
  logic [7:0]  rx_data, tx_data;
  logic        rx_valid, rx_ferr, tx_start, tx_busy, tx_accept;
  logic [1:0]  byte_cnt_q;
  logic [23:0] addr_sh_q;
  logic [15:0] tcnt_q;
  logic [31:0] resp_q;
  logic [2:0]  resp_left_q;
  logic        q_pend_q;
  logic        is_cmd, last_byte, timed_out;

  uart_byte_phy #(.UARTSPED(UARTSPED)) u_phy (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .rx       (uartRx_i),
    .tx       (uartTx_o),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy)
  );

  assign is_cmd    = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);
  assign last_byte = rx_valid && (byte_cnt_q == 2'd3);
  assign timed_out = (tcnt_q == TIMEOUT);
  assign stb_o     = (state_q == S_BUS);
  assign sel_o     = {4{stb_o}};
  assign tx_accept = tx_start && !tx_busy;

  // A pending '?' for an unknown command goes out ahead of any frame response.
  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    tx_data  = resp_q[31:24];
    if (q_pend_q) begin
      tx_start = 1'b1;
      tx_data  = RSP_UNKNOWN;
    end else if (state_q == S_RESP) begin
      tx_start = 1'b1;
    end
    case (state_q)
      S_IDLE: if (rx_valid && is_cmd) state_d = S_ADDR;
      S_ADDR: begin
        if (rx_ferr) state_d = S_IDLE;
        else if (last_byte) state_d = we_o ? S_DATA : S_BUS;
      end
      S_DATA: begin
        if (rx_ferr) state_d = S_IDLE;
        else if (last_byte) state_d = S_BUS;
      end
      S_BUS:  if (ack_i || timed_out) state_d = S_RESP;
      S_RESP: if (tx_accept && !q_pend_q && resp_left_q == 3'd1) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      addr_sh_q   <= '0;
      tcnt_q      <= '0;
      resp_q      <= '0;
      resp_left_q <= '0;
      q_pend_q    <= 1'b0;
      we_o        <= 1'b0;
      adr_o       <= '0;
      dat_o       <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= stb_o ? tcnt_q + 16'd1 : 16'd0;
      if (q_pend_q && !tx_busy) q_pend_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_valid) begin
            if (is_cmd) begin
              we_o       <= (rx_data == CMD_WRITE);
              byte_cnt_q <= 2'd0;
            end else begin
              q_pend_q <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            addr_sh_q  <= {addr_sh_q[15:0], rx_data};
            if (last_byte) adr_o <= {addr_sh_q, rx_data[7:2], 2'b00};
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            dat_o      <= {dat_o[23:0], rx_data};
          end
        end
        S_BUS: begin
          if (ack_i) begin
            resp_q      <= we_o ? {RSP_OK, 24'h0} : dat_i;
            resp_left_q <= we_o ? 3'd1 : 3'd4;
          end else if (timed_out) begin
            resp_q      <= {RSP_ERR, 24'h0};
            resp_left_q <= 3'd1;
          end
        end
        S_RESP: begin
          if (tx_accept && !q_pend_q) begin
            resp_q      <= {resp_q[23:0], 8'h00};
            resp_left_q <= resp_left_q - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
